fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Decoupling FIFO between the fetch/PC stage and decode. Buffers fetched instruction
//  bundles {pc, inst, epoch, pred_taken, pred_target}. Drops stale-epoch bundles and
//  flushes everything on redirect, so decode only sees current-path instructions.
//  Sits directly downstream of the fetch stage.
// PARAMETERS
//  DEPTH    4   entries; power of two, >= 2
//  CNT_W    16  width of the saturating drop counter
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      reset, asynchronous, active-low
//  flush           in   1      redirect from backend; same pulse that toggles fetch epoch
//  in_valid        in   1      fetch bundle valid
//  in_ready        out  1      queue can accept (also fetch's fetch_ready)
//  in_pc           in   32     bundle PC
//  in_inst         in   32     bundle instruction
//  in_epoch        in   1      epoch tag of bundle
//  in_pred_taken   in   1      predictor taken
//  in_pred_target  in   32     predictor target
//  out_valid       out  1      head entry valid to decode
//  out_ready       in   1      decode accepts head
//  out_pc          out  32     head PC
//  out_inst        out  32     head instruction
//  out_epoch       out  1      head epoch
//  out_pred_taken  out  1      head predicted taken
//  out_pred_target out  32     head predicted target
//  count           out  $clog2(DEPTH+1)  occupancy
//  drop_cnt        out  CNT_W  saturating count of stale bundles discarded
// BEHAVIOUR
//  - Reset: epoch_q=0, head=tail=0, count=0, drop_cnt=0; out_valid=0, in_ready=1,
//    out_* data=0 (storage cleared).
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH), from registered count only. No bypass: a pop in the
//    same cycle does not open a slot for a push when full.
//  - out_valid = (count != 0); out_* driven combinationally from entry[head].
//  - Latency: pushed bundle is visible at out_* the cycle after the push (no flow-through).
//  - Stale filter: a push with in_epoch != epoch_q is consumed (handshake completes) but
//    not written; drop_cnt += 1, saturating at all-ones.
//  - Write: a push with in_epoch == epoch_q and no flush writes entry[tail], tail += 1.
//  - Pop: head += 1. Pointers are $clog2(DEPTH) bits and wrap naturally.
//  - count_next = count + write - pop; push+pop when 0 < count < DEPTH leaves count
//    unchanged.
//  - Flush (highest priority):
//    - next cycle head=tail=0, count=0;
//    - epoch_q toggles;
//    - any push that cycle is discarded and is NOT counted in drop_cnt;
//    - a pop that cycle still completes from decode's view, but has no effect on state;
//    - in_ready stays as computed from count (flush does not gate it).
//  - After a flush, in-flight bundles carrying the old epoch are dropped. Bundles from
//    the redirected PC carry the new epoch and are accepted.
//  - Reset mid-operation: asynchronous clear of all state to reset values; no partial
//    entries survive.
// TESTING
//  1 Reset, push pc=0x0,4,8 (epoch 0) with out_ready=0 -> count=3, out_pc=0x0, in_ready=1.
//  2 DEPTH=4, fill 4 with out_ready=0 -> in_ready=0; then push+pop same cycle -> only the
//    pop occurs, count=3.
//  3 Stream 10 bundles with out_ready=1 continuously -> in-order out_pc 0x0..0x24, one
//    per cycle after 1-cycle latency; pointers wrap; count <= 1.
//  4 3 entries queued, flush=1 with a push of pc=0x40 -> next cycle count=0, out_valid=0,
//    drop_cnt unchanged, epoch_q=1.
//  5 After test 4, push pc=0x44 epoch 0 then pc=0x80 epoch 1 -> 0x44 dropped
//    (drop_cnt=1), out_pc=0x80, out_epoch=1.
//  6 Force drop_cnt to all-ones via repeated stale pushes -> stays all-ones; then assert
//    rst_n=0 mid-stream -> all outputs reset immediately.

Source files
------------

// File: rtl/fetch_queue.sv
// Purpose: decoupling FIFO between fetch and decode; drops stale-epoch bundles and empties on flush.
// Latency: a written bundle appears at out_* one cycle after its push; no flow-through path.
// Backpressure: in_ready = (count != DEPTH) from registered count; a same-cycle pop never frees a slot.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   flush            redirect pulse; empties the queue and toggles the expected epoch
//   in_*             fetch bundle {pc, inst, epoch, pred_taken, pred_target} with valid/ready
//   out_*            head bundle to decode with valid/ready
//   count            current occupancy
//   drop_cnt         saturating count of stale-epoch bundles discarded
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_epoch,
  input  logic                       in_pred_taken,
  input  logic [31:0]                in_pred_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_epoch,
  output logic                       out_pred_taken,
  output logic [31:0]                out_pred_target,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 32 + 32 + 1 + 1 + 32;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             epoch_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;

  logic push;
  logic pop;
  logic stale;
  logic wr;
  logic drop;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign stale = (in_epoch != epoch_q);
  // A flush discards the push outright, so it neither writes nor counts as a drop.
  assign wr    = push & ~stale & ~flush;
  assign drop  = push &  stale & ~flush;

  assign {out_pc, out_inst, out_epoch, out_pred_taken, out_pred_target} = mem[head];

  always_comb begin
    count_nxt = count_q;
    case ({wr, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      epoch_q  <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Decode still sees its handshake complete, but a pop here changes nothing.
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      epoch_q <= ~epoch_q;
    end else begin
      if (wr) begin
        mem[tail] <= {in_pc, in_inst, in_epoch, in_pred_taken, in_pred_target};
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count_q <= count_nxt;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
